booth_mult_seq: RTL and testbench



---
 rtl/booth_mult_seq_pkg.sv | 34 +++
 rtl/booth_mult_seq_step.sv | 36 +++
 rtl/booth_mult_seq.sv | 118 +++++++++++
 tb/tb_booth_mult_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM encodings, flag bit positions and the Booth recoding decision.
package booth_mult_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_E = 3;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_e;

  // Radix-2 recoding of the pair {Q[0], q_1}: 01 adds M, 10 subtracts M.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    booth_op_e op;
    op = OP_NONE;
    case ({q0, q_1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One combinational Booth iteration: conditional add/subtract of M into A,
// then an arithmetic right shift of the combined {A, Q, q_1} register.
module booth_mult_seq_step
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_1
);

  booth_op_e        w_op;
  logic [WIDTH:0]   w_sum;

  assign w_op = booth_decode(i_q[0], i_q_1);

  // A carries one guard bit, so subtracting the most negative M cannot wrap.
  always_comb begin
    w_sum = i_a;
    case (w_op)
      OP_ADD:  w_sum = i_a + i_m;
      OP_SUB:  w_sum = i_a - i_m;
      default: w_sum = i_a;
    endcase
  end

  assign o_a   = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_q_1 = i_q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: accepts signed operands on start,
// runs one iteration per clock and presents the product plus {E,V,N,Z} flags.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product,
  output logic [3:0]         o_flags
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH:0]     r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_1;
  logic [WIDTH:0]     r_m;
  logic               r_err;
  logic [2*WIDTH-1:0] r_product;
  logic [3:0]         r_flags;

  logic [WIDTH:0]     w_next_a;
  logic [WIDTH-1:0]   w_next_q;
  logic               w_next_q_1;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH:0]     w_upper;
  logic [3:0]         w_flags;

  booth_mult_seq_step #(.WIDTH(WIDTH)) u_step (
    .i_a   (r_a),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_a   (w_next_a),
    .o_q   (w_next_q),
    .o_q_1 (w_next_q_1)
  );

  // Result as it will stand after the final iteration; only captured then.
  assign w_product = {w_next_a[WIDTH-1:0], w_next_q};
  assign w_upper   = w_product[2*WIDTH-1:WIDTH-1];

  always_comb begin
    w_flags         = 4'b0000;
    w_flags[FLAG_Z] = (w_product == '0);
    w_flags[FLAG_N] = w_product[2*WIDTH-1];
    w_flags[FLAG_V] = !((&w_upper) || !(|w_upper));
    w_flags[FLAG_E] = r_err || i_start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_q_1     <= 1'b0;
      r_m       <= '0;
      r_err     <= 1'b0;
      r_product <= '0;
      r_flags   <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_m     <= {i_multiplicand[WIDTH-1], i_multiplicand};
            r_q     <= i_multiplier;
            r_a     <= '0;
            r_q_1   <= 1'b0;
            r_count <= CW'(WIDTH);
            r_err   <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= w_next_a;
          r_q     <= w_next_q;
          r_q_1   <= w_next_q_1;
          r_count <= r_count - 1'b1;
          if (i_start) begin
            r_err <= 1'b1;
          end
          if (r_count == CW'(1)) begin
            r_product <= w_product;
            r_flags   <= w_flags;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A late start still belongs to the result being presented.
          if (i_start) begin
            r_err            <= 1'b1;
            r_flags[FLAG_E]  <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_DONE);
  assign o_product = r_product;
  assign o_flags   = r_flags;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed cases plus a random
// back-to-back sweep compared against plain signed arithmetic.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [7:0]  i_multiplicand;
  logic [7:0]  i_multiplier;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_product;
  logic [3:0]  o_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_product      (o_product),
    .o_flags        (o_flags)
  );

  function automatic logic [15:0] refProduct(input logic [7:0] m, input logic [7:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[15:0];
  endfunction

  function automatic logic [3:0] refFlags(input logic [7:0] m, input logic [7:0] q, input logic e);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return {e, (p > 127 || p < -128), (p < 0), (p == 0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive operands with start for one cycle; returns at the first sample after acceptance.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] q);
    i_multiplicand = m;
    i_multiplier   = q;
    i_start        = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Scrambles operand inputs while waiting, since they must be ignored during RUN.
  task automatic waitDone(input int firstCycle, output int doneCycle, output int busyCycles);
    doneCycle  = -1;
    busyCycles = 0;
    for (int c = firstCycle; c < firstCycle + 24; c++) begin
      if (o_busy) busyCycles++;
      if (o_done) begin
        doneCycle = c;
        break;
      end
      i_multiplicand = 8'($urandom);
      i_multiplier   = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic checkResult(input string tag, input logic [7:0] m, input logic [7:0] q,
                             input logic expE, input int firstCycle);
    int doneCycle;
    int busyCycles;
    waitDone(firstCycle, doneCycle, busyCycles);
    checkOutput({tag, ".doneCycle"}, 16'(doneCycle), 16'd9);
    checkOutput({tag, ".busyCycles"}, 16'(busyCycles), 16'(10 - firstCycle));
    checkOutput({tag, ".product"}, o_product, refProduct(m, q));
    checkOutput({tag, ".flags"}, 16'(o_flags), 16'(refFlags(m, q, expE)));
    @(negedge clk);
    checkOutput({tag, ".idleBusy"}, 16'(o_busy), 16'd0);
    checkOutput({tag, ".idleDone"}, 16'(o_done), 16'd0);
  endtask

  initial begin
    logic [15:0] prevProd;
    logic [7:0]  m;
    logic [7:0]  q;
    logic        sawDone;
    logic [7:0]  corners [6];

    reset          = 1'b1;
    i_start        = 1'b0;
    i_multiplicand = 8'h00;
    i_multiplier   = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset.busy", 16'(o_busy), 16'd0);
    checkOutput("reset.done", 16'(o_done), 16'd0);
    checkOutput("reset.product", o_product, 16'h0000);
    checkOutput("reset.flags", 16'(o_flags), 16'h0);

    // Reset together with start must win.
    i_start = 1'b1;
    i_multiplicand = 8'd3;
    i_multiplier = 8'd3;
    @(negedge clk);
    i_start = 1'b0;
    reset   = 1'b0;
    checkOutput("resetStart.busy", 16'(o_busy), 16'd0);
    @(negedge clk);

    applyStimulus(8'd3, 8'd5);
    checkResult("m3q5", 8'd3, 8'd5, 1'b0, 1);
    checkOutput("m3q5.prodConst", o_product, 16'h000F);

    applyStimulus(8'h80, 8'h80);
    checkResult("minmin", 8'h80, 8'h80, 1'b0, 1);
    checkOutput("minmin.flagsConst", 16'(o_flags), 16'h4);

    applyStimulus(8'hFF, 8'h01);
    checkResult("neg1", 8'hFF, 8'h01, 1'b0, 1);
    checkOutput("neg1.flagsConst", 16'(o_flags), 16'h2);

    applyStimulus(8'h00, 8'hB3);
    checkResult("zero", 8'h00, 8'hB3, 1'b0, 1);
    checkOutput("zero.flagsConst", 16'(o_flags), 16'h1);

    // Second start during RUN cycle 3 must be ignored but flagged.
    applyStimulus(8'd7, 8'd9);
    repeat (2) @(negedge clk);
    i_multiplicand = 8'd2;
    i_multiplier   = 8'd2;
    i_start        = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checkResult("busyStart", 8'd7, 8'd9, 1'b1, 4);
    checkOutput("busyStart.prodConst", o_product, 16'h003F);
    applyStimulus(8'd2, 8'd2);
    checkResult("clearE", 8'd2, 8'd2, 1'b0, 1);

    // Reset during RUN cycle 4 discards the computation.
    applyStimulus(8'd10, 8'd10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midReset.busy", 16'(o_busy), 16'd0);
    checkOutput("midReset.done", 16'(o_done), 16'd0);
    checkOutput("midReset.product", o_product, 16'h0000);
    checkOutput("midReset.flags", 16'(o_flags), 16'h0);
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (o_done) sawDone = 1'b1;
      @(negedge clk);
    end
    checkOutput("midReset.noSpuriousDone", 16'(sawDone), 16'd0);
    applyStimulus(8'd10, 8'd10);
    checkResult("afterReset", 8'd10, 8'd10, 1'b0, 1);
    checkOutput("afterReset.prodConst", o_product, 16'h0064);

    corners[0] = 8'h80;
    corners[1] = 8'h7F;
    corners[2] = 8'h00;
    corners[3] = 8'hFF;
    corners[4] = 8'h01;
    corners[5] = 8'h81;
    prevProd = o_product;
    for (int i = 0; i < 336; i++) begin
      if (i < 36) begin
        m = corners[i / 6];
        q = corners[i % 6];
      end else begin
        m = 8'($urandom);
        q = 8'($urandom);
      end
      applyStimulus(m, q);
      checkOutput("sweep.heldProduct", o_product, prevProd);
      checkResult("sweep", m, q, 1'b0, 1);
      prevProd = refProduct(m, q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
